acc_processor_param: RTL

Parametrised successor to the team's single-cycle accumulator processor. It keeps the same 4-bit-opcode accumulator ISA and adds a programmable instruction memory and a loadable register file. Execution is a two-phase FETCH/EXEC state machine with a start/busy/halted handshake. It sits under a host controller that loads the program and registers, starts a run, and reads results.

---
 rtl/acc_processor_param.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/acc_processor_param.sv
// acc_processor_param: parametrised two-phase (FETCH/EXEC) accumulator processor
// with a host-loadable instruction memory and register file.
// Optional build macro: TINYPROC_WDOG_EN adds an instruction-budget watchdog
// and the wdog_trip output.
module acc_processor_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OPND_W     = 4,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [OPND_W-1:0]   prog_addr,
  input  logic [OPND_W+3:0]   prog_data,
  input  logic                rf_we,
  input  logic [OPND_W-1:0]   rf_addr,
  input  logic [DATA_W-1:0]   rf_wdata,
  input  logic                start,
  output logic                busy,
  output logic                halted,
  output logic [DATA_W-1:0]   acc_out,
  output logic [DATA_W-1:0]   ext_out,
  output logic                cb_out,
  output logic [OPND_W-1:0]   pc_out
`ifdef TINYPROC_WDOG_EN
  ,
  output logic                wdog_trip
`endif
);

  localparam int unsigned INSTR_W = OPND_W + 4;
  localparam int unsigned DEPTH   = 1 << OPND_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_MISC = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_MUL  = 4'b0011,
    OP_AND  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_CMP  = 4'b0111,
    OP_JC   = 4'b1000,
    OP_LDR  = 4'b1001,
    OP_STR  = 4'b1010,
    OP_JMP  = 4'b1011
  } opcode_t;

  state_t              state, state_nx;
  logic [INSTR_W-1:0]  imem [DEPTH];
  logic [DATA_W-1:0]   rf   [DEPTH];
  logic [INSTR_W-1:0]  ir;
  logic [OPND_W-1:0]   pc, pc_nx;
  logic [DATA_W-1:0]   acc, acc_nx;
  logic [DATA_W-1:0]   ext, ext_nx;
  logic                cb, cb_nx;
  logic                rf_st;
  logic                is_hlt;
  logic                ctl_open;
  logic                wdog_hit;
  opcode_t             op;
  logic [OPND_W-1:0]   n;
  logic [DATA_W-1:0]   rval;
  logic [DATA_W:0]     sum, diff, inc, dec;
  logic [2*DATA_W-1:0] prod;

  assign op       = opcode_t'(ir[INSTR_W-1 -: 4]);
  assign n        = ir[OPND_W-1:0];
  assign rval     = rf[n];
  assign is_hlt   = &ir;
  assign ctl_open = (state == S_IDLE) || (state == S_HALT);

  // Carry/borrow is the extra MSB of each widened result.
  assign sum  = {1'b0, acc} + {1'b0, rval};
  assign diff = {1'b0, acc} - {1'b0, rval};
  assign inc  = {1'b0, acc} + (DATA_W+1)'(1);
  assign dec  = {1'b0, acc} - (DATA_W+1)'(1);
  assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, rval};

  assign busy    = (state == S_FETCH) || (state == S_EXEC);
  assign halted  = (state == S_HALT);
  assign acc_out = acc;
  assign ext_out = ext;
  assign cb_out  = cb;
  assign pc_out  = pc;

  // Instruction execution: results of the instruction held in ir.
  always_comb begin
    acc_nx = acc;
    ext_nx = ext;
    cb_nx  = cb;
    pc_nx  = pc + OPND_W'(1);
    rf_st  = 1'b0;
    case (op)
      OP_ADD: {cb_nx, acc_nx} = sum;
      OP_SUB: {cb_nx, acc_nx} = diff;
      OP_MUL: {ext_nx, acc_nx} = prod;
      OP_AND: acc_nx = acc & rval;
      OP_XOR: acc_nx = acc ^ rval;
      OP_CMP: cb_nx = diff[DATA_W];
      OP_JC:  if (cb) pc_nx = n;
      OP_LDR: acc_nx = rval;
      OP_STR: rf_st = 1'b1;
      OP_JMP: pc_nx = n;
      OP_MISC: begin
        case (n)
          OPND_W'(1): acc_nx = {acc[DATA_W-2:0], 1'b0};
          OPND_W'(2): acc_nx = {1'b0, acc[DATA_W-1:1]};
          OPND_W'(3): acc_nx = {acc[DATA_W-2:0], acc[DATA_W-1]};
          OPND_W'(4): acc_nx = {acc[0], acc[DATA_W-1:1]};
          OPND_W'(5): acc_nx = {acc[DATA_W-1], acc[DATA_W-1:1]};
          OPND_W'(6): {cb_nx, acc_nx} = inc;
          OPND_W'(7): {cb_nx, acc_nx} = dec;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef TINYPROC_WDOG_EN
  logic [31:0] wdog_cnt;

  assign wdog_hit = ((wdog_cnt + 32'd1) >= WDOG_LIMIT) && !is_hlt;

  // Watchdog: counts EXEC cycles since start, trips into HALT at the budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (ctl_open && start) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (state == S_EXEC) begin
      wdog_cnt <= wdog_cnt + 32'd1;
      if (wdog_hit) wdog_trip <= 1'b1;
    end
  end
`else
  logic unused_wdog;

  assign wdog_hit    = 1'b0;
  assign unused_wdog = (WDOG_LIMIT == 32'd0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE,
      S_HALT:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_EXEC;
      S_EXEC:  state_nx = (is_hlt || wdog_hit) ? S_HALT : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and register file; host writes only while not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      acc <= '0;
      ext <= '0;
      cb  <= 1'b0;
      ir  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE,
        S_HALT: begin
          if (rf_we) rf[rf_addr] <= rf_wdata;
          if (start) pc <= '0;
        end
        S_FETCH: ir <= imem[pc];
        S_EXEC: begin
          acc <= acc_nx;
          ext <= ext_nx;
          cb  <= cb_nx;
          pc  <= pc_nx;
          if (rf_st) rf[n] <= acc;
        end
        default: ;
      endcase
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && ctl_open) imem[prog_addr] <= prog_data;
  end

endmodule
